// File: rtl/bridge_pkg.sv
// Shared constants for the CPU bridge: region bases, window offsets, interrupt bit indices.
package bridge_pkg;

  localparam logic [31:0] DM_TOP    = 32'h0000_2FFF;
  localparam logic [31:0] TC0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] INT_BASE  = 32'h0000_7F20;
  localparam logic [31:0] WIN_BYTES = 32'd12;

  // Byte offsets inside a 12-byte window; bases are 16-byte aligned so addr[3:0] is the offset.
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_ACK    = 4'h0;
  localparam logic [3:0] OFF_MASK   = 4'h4;
  localparam logic [3:0] OFF_PEND   = 4'h8;

  localparam int IRQ_TC0 = 0;
  localparam int IRQ_TC1 = 1;
  localparam int IRQ_EXT = 2;

  typedef enum logic [2:0] {
    RGN_NONE = 3'd0,
    RGN_DM   = 3'd1,
    RGN_TC0  = 3'd2,
    RGN_TC1  = 3'd3,
    RGN_INT  = 3'd4
  } region_e;

  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base) && (addr < base + WIN_BYTES);
  endfunction

endpackage

// File: rtl/sys_bridge_irq_ctrl_if.sv
// CPU M-stage data port as seen by the bridge.
interface sys_bridge_irq_ctrl_if;
  // No valid/ready: the port is single-cycle. A store is present when cpu_byteen != 0,
  // a load when cpu_load = 1; cpu_rdata and the error flags answer combinationally in
  // the same cycle, and side effects commit at the clock edge that ends the cycle.
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_load;
  logic        cpu_ld_word;
  logic        exc_kill;
  logic [31:0] cpu_rdata;
  logic        err_load;
  logic        err_store;

  modport master (
    output cpu_addr, cpu_wdata, cpu_byteen, cpu_load, cpu_ld_word, exc_kill,
    input  cpu_rdata, err_load, err_store
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_byteen, cpu_load, cpu_ld_word, exc_kill,
    output cpu_rdata, err_load, err_store
  );
endinterface

// File: rtl/irq_pend_unit.sv
// Sticky, maskable interrupt-pending state with rising-edge capture.
// IRQ_SYNC_EN adds a 2-flop synchronizer on every source ahead of edge detection.
module irq_pend_unit
  import bridge_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] irq_in,
  input  logic       mask_we,
  input  logic [2:0] mask_wdata,
  input  logic [2:0] pend_clr,
  output logic [2:0] mask_o,
  output logic [2:0] pend_o,
  output logic [5:0] hwint
);

  logic [2:0] level;
  logic [2:0] prev_q, prev_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] mask_q, mask_d;

`ifdef IRQ_SYNC_EN
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
    level   = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
`else
  always_comb begin
    level = irq_in;
  end
`endif

  // A new edge beats a clear landing in the same cycle.
  always_comb begin
    prev_d = level;
    pend_d = (pend_q & ~pend_clr) | (level & ~prev_q);
    mask_d = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 3'b000;
      pend_q <= 3'b000;
      mask_q <= 3'b111;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    mask_o = mask_q;
    pend_o = pend_q;
    hwint  = {3'b000, pend_q & mask_q};
  end

endmodule

// File: rtl/sys_bridge_irq_ctrl.sv
// Bridge between the CPU M-stage data port and DM, TC0, TC1 and the interrupt window.
// Build option IRQ_SYNC_EN (inside irq_pend_unit) synchronizes the interrupt sources.
module sys_bridge_irq_ctrl
  import bridge_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  sys_bridge_irq_ctrl_if.slave   cpu,
  output logic [31:0]            dm_addr,
  output logic [31:0]            dm_wdata,
  output logic [3:0]             dm_byteen,
  input  logic [31:0]            dm_rdata,
  output logic                   tc0_we,
  output logic                   tc1_we,
  output logic [29:0]            tc_addr,
  output logic [31:0]            tc_wdata,
  input  logic [31:0]            tc0_rdata,
  input  logic [31:0]            tc1_rdata,
  input  logic                   irq_tc0,
  input  logic                   irq_tc1,
  input  logic                   irq_ext,
  output logic [31:0]            int_addr,
  output logic [3:0]             int_byteen,
  output logic [5:0]             hwint
);

  region_e    region;
  logic [3:0] woff;
  logic       st, ld, is_tc, is_int, full_word, wr_ok;
  logic       mask_we;
  logic [2:0] pend_clr;
  logic [2:0] mask_v, pend_v;

  always_comb begin
    region = RGN_NONE;
    if (cpu.cpu_addr <= DM_TOP)                  region = RGN_DM;
    else if (in_window(cpu.cpu_addr, TC0_BASE))  region = RGN_TC0;
    else if (in_window(cpu.cpu_addr, TC1_BASE))  region = RGN_TC1;
    else if (in_window(cpu.cpu_addr, INT_BASE))  region = RGN_INT;
  end

  always_comb begin
    woff      = {cpu.cpu_addr[3:2], 2'b00};
    st        = (|cpu.cpu_byteen) & ~cpu.exc_kill;
    ld        = cpu.cpu_load & ~cpu.exc_kill;
    is_tc     = (region == RGN_TC0) || (region == RGN_TC1);
    is_int    = (region == RGN_INT);
    full_word = (cpu.cpu_byteen == 4'hF);

    // Peripheral windows take word accesses only; COUNT is read-only.
    cpu.err_store = st & ((region == RGN_NONE)
                          | ((is_tc | is_int) & ~full_word)
                          | (is_tc & (woff == OFF_COUNT)));
    cpu.err_load  = ld & ((region == RGN_NONE)
                          | ((is_tc | is_int) & ~cpu.cpu_ld_word));
    wr_ok = st & ~cpu.err_store & ~cpu.err_load;
  end

  always_comb begin
    dm_addr    = cpu.cpu_addr;
    dm_wdata   = cpu.cpu_wdata;
    dm_byteen  = (wr_ok && region == RGN_DM) ? cpu.cpu_byteen : 4'h0;
    tc0_we     = wr_ok && (region == RGN_TC0);
    tc1_we     = wr_ok && (region == RGN_TC1);
    tc_addr    = cpu.cpu_addr[31:2];
    tc_wdata   = cpu.cpu_wdata;
    int_addr   = cpu.cpu_addr;
    int_byteen = (wr_ok && is_int && woff == OFF_ACK) ? cpu.cpu_byteen : 4'h0;
    mask_we    = wr_ok && is_int && (woff == OFF_MASK);
  end

  always_comb begin
    pend_clr          = 3'b000;
    pend_clr[IRQ_TC0] = tc0_we && (woff == OFF_CTRL);
    pend_clr[IRQ_TC1] = tc1_we && (woff == OFF_CTRL);
    pend_clr[IRQ_EXT] = |int_byteen;
    if (wr_ok && is_int && woff == OFF_PEND)
      pend_clr = pend_clr | cpu.cpu_wdata[2:0];
  end

  always_comb begin
    cpu.cpu_rdata = 32'h0;
    case (region)
      RGN_DM:  cpu.cpu_rdata = dm_rdata;
      RGN_TC0: cpu.cpu_rdata = tc0_rdata;
      RGN_TC1: cpu.cpu_rdata = tc1_rdata;
      RGN_INT: begin
        if (woff == OFF_MASK)      cpu.cpu_rdata = {29'h0, mask_v};
        else if (woff == OFF_PEND) cpu.cpu_rdata = {29'h0, pend_v};
      end
      default: cpu.cpu_rdata = 32'h0;
    endcase
  end

  irq_pend_unit u_irq_pend_unit (
    .clk        (clk),
    .reset      (reset),
    .irq_in     ({irq_ext, irq_tc1, irq_tc0}),
    .mask_we    (mask_we),
    .mask_wdata (cpu.cpu_wdata[2:0]),
    .pend_clr   (pend_clr),
    .mask_o     (mask_v),
    .pend_o     (pend_v),
    .hwint      (hwint)
  );

endmodule

// File: tb/tb_sys_bridge_irq_ctrl.sv
// Bench for sys_bridge_irq_ctrl: directed scenarios then randomized traffic against a reference model.
module tb_sys_bridge_irq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sys_bridge_irq_ctrl_if cpu_if ();

  logic [31:0] dm_addr, dm_wdata, dm_rdata, tc_wdata, tc0_rdata, tc1_rdata, int_addr;
  logic [3:0]  dm_byteen, int_byteen;
  logic        tc0_we, tc1_we;
  logic [29:0] tc_addr;
  logic        irq_tc0, irq_tc1, irq_ext;
  logic [5:0]  hwint;

  sys_bridge_irq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu_if.slave),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_byteen  (dm_byteen),
    .dm_rdata   (dm_rdata),
    .tc0_we     (tc0_we),
    .tc1_we     (tc1_we),
    .tc_addr    (tc_addr),
    .tc_wdata   (tc_wdata),
    .tc0_rdata  (tc0_rdata),
    .tc1_rdata  (tc1_rdata),
    .irq_tc0    (irq_tc0),
    .irq_tc1    (irq_tc1),
    .irq_ext    (irq_ext),
    .int_addr   (int_addr),
    .int_byteen (int_byteen),
    .hwint      (hwint)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: predicted hwint after each clock edge.
  logic [5:0] exp_q[$];

  // Reference model: interrupt state as seen by software.
  logic [2:0] m_pend, m_mask, m_prev;
  logic [2:0] lvl_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    if (a <= 32'h0000_2FFF) return 0;
    if (a >= 32'h0000_7F00 && a < 32'h0000_7F0C) return 1;
    if (a >= 32'h0000_7F10 && a < 32'h0000_7F1C) return 2;
    if (a >= 32'h0000_7F20 && a < 32'h0000_7F2C) return 3;
    return 4;
  endfunction

  function automatic logic [31:0] base_of(input int r);
    case (r)
      1: return 32'h0000_7F00;
      2: return 32'h0000_7F10;
      3: return 32'h0000_7F20;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drv(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input logic ld, input logic ldw, input logic kill);
    cpu_if.cpu_addr    = a;
    cpu_if.cpu_wdata   = wd;
    cpu_if.cpu_byteen  = be;
    cpu_if.cpu_load    = ld;
    cpu_if.cpu_ld_word = ldw;
    cpu_if.exc_kill    = kill;
  endtask

  task automatic idle();
    drv(32'h0000_0100, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // One bus cycle: check combinational outputs, advance the model across the edge, check hwint after.
  task automatic step();
    logic [31:0] a, base, exp_rd;
    int          r, w;
    logic        st, ld, is_tc, es, el, ok, e_tc0, e_tc1, rst_now;
    logic [3:0]  exp_dmbe, exp_intbe;
    logic [2:0]  clr, lvl, wd3;
    logic        mask_wr;
    #1;
    a    = cpu_if.cpu_addr;
    r    = region_of(a);
    base = base_of(r);
    w    = (r >= 1 && r <= 3) ? int'((a - base) / 4) : -1;
    st   = (cpu_if.cpu_byteen != 4'h0) && !cpu_if.exc_kill;
    ld   = cpu_if.cpu_load && !cpu_if.exc_kill;
    is_tc = (r == 1 || r == 2);
    es   = st && (r == 4 || ((is_tc || r == 3) && cpu_if.cpu_byteen != 4'hF) || (is_tc && w == 2));
    el   = ld && (r == 4 || ((is_tc || r == 3) && !cpu_if.cpu_ld_word));
    ok   = st && !es && !el;
    exp_dmbe  = (ok && r == 0) ? cpu_if.cpu_byteen : 4'h0;
    e_tc0     = ok && r == 1;
    e_tc1     = ok && r == 2;
    exp_intbe = (ok && r == 3 && w == 0) ? cpu_if.cpu_byteen : 4'h0;
    case (r)
      0: exp_rd = dm_rdata;
      1: exp_rd = tc0_rdata;
      2: exp_rd = tc1_rdata;
      3: exp_rd = (w == 1) ? {29'h0, m_mask} : (w == 2) ? {29'h0, m_pend} : 32'h0;
      default: exp_rd = 32'h0;
    endcase
    check("err_store",  {31'h0, cpu_if.err_store}, {31'h0, es});
    check("err_load",   {31'h0, cpu_if.err_load},  {31'h0, el});
    check("dm_byteen",  {28'h0, dm_byteen},  {28'h0, exp_dmbe});
    check("tc0_we",     {31'h0, tc0_we},     {31'h0, e_tc0});
    check("tc1_we",     {31'h0, tc1_we},     {31'h0, e_tc1});
    check("int_byteen", {28'h0, int_byteen}, {28'h0, exp_intbe});
    check("cpu_rdata",  cpu_if.cpu_rdata, exp_rd);
    check("dm_addr",    dm_addr, a);
    check("dm_wdata",   dm_wdata, cpu_if.cpu_wdata);
    check("tc_addr",    {2'b00, tc_addr}, {2'b00, a[31:2]});
    check("tc_wdata",   tc_wdata, cpu_if.cpu_wdata);
    check("int_addr",   int_addr, a);
    check("hwint_pre",  {26'h0, hwint}, {26'h0, 3'b000, m_pend & m_mask});

    wd3 = cpu_if.cpu_wdata[2:0];
    clr = 3'b000;
    if (e_tc0 && w == 0) clr[0] = 1'b1;
    if (e_tc1 && w == 0) clr[1] = 1'b1;
    if (exp_intbe != 4'h0) clr[2] = 1'b1;
    if (ok && r == 3 && w == 2) clr = clr | wd3;
    mask_wr = ok && r == 3 && w == 1;
    rst_now = reset;

    @(posedge clk);
    if (rst_now) begin
      m_pend = 3'b000;
      m_mask = 3'b111;
      m_prev = 3'b000;
      lvl_q  = '{3'b000, 3'b000};
    end else begin
`ifdef IRQ_SYNC_EN
      lvl_q.push_back({irq_ext, irq_tc1, irq_tc0});
      lvl = lvl_q.pop_front();
`else
      lvl = {irq_ext, irq_tc1, irq_tc0};
`endif
      m_pend = (m_pend & ~clr) | (lvl & ~m_prev);
      if (mask_wr) m_mask = wd3;
      m_prev = lvl;
    end
    exp_q.push_back({3'b000, m_pend & m_mask});
    #1;
    check("hwint_post", {26'h0, hwint}, {26'h0, exp_q.pop_front()});
    @(negedge clk);
  endtask

  task automatic sync_wait();
`ifdef IRQ_SYNC_EN
    idle(); step();
    idle(); step();
`endif
  endtask

  initial begin
    logic [3:0] be_tab[8];
    logic [31:0] a;
    be_tab = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h1, 4'h3, 4'hC, 4'h8};
    m_pend = 3'b000; m_mask = 3'b111; m_prev = 3'b000;
    lvl_q = '{3'b000, 3'b000};
    irq_tc0 = 1'b0; irq_tc1 = 1'b0; irq_ext = 1'b0;
    dm_rdata = 32'hD00D_F00D; tc0_rdata = 32'h0000_0C00; tc1_rdata = 32'h0000_0C11;
    idle();
    @(negedge clk);
    repeat (3) step();
    reset = 1'b0;

    // DM word store and load back
    drv(32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b0); #1;
    check("sw_dm_be", {28'h0, dm_byteen}, 32'hF);
    step();
    drv(32'h0000_0010, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); #1;
    check("lw_dm_rd", cpu_if.cpu_rdata, 32'hD00D_F00D);
    step();

    // Size / range errors
    drv(32'h0000_7F04, 32'h0, 4'h1, 1'b0, 1'b0, 1'b0); #1;
    check("sb_tc_err", {31'h0, cpu_if.err_store}, 32'h1);
    check("sb_tc_we",  {31'h0, tc0_we}, 32'h0);
    step();
    drv(32'h0000_7F08, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0); #1;
    check("sw_count_err", {31'h0, cpu_if.err_store}, 32'h1);
    step();
    drv(32'h0000_7F14, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0); #1;
    check("lh_tc_err", {31'h0, cpu_if.err_load}, 32'h1);
    step();
    drv(32'h0000_5000, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); #1;
    check("lw_unmap_err", {31'h0, cpu_if.err_load}, 32'h1);
    check("lw_unmap_rd",  cpu_if.cpu_rdata, 32'h0);
    step();
    idle(); step(); idle(); step();

    // External interrupt edge, then ACK
    irq_ext = 1'b1;
    idle(); step();
    sync_wait();
    check("ext_hwint", {26'h0, hwint}, 32'h04);
    drv(32'h0000_7F20, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0); #1;
    check("ack_be", {28'h0, int_byteen}, 32'hF);
    step();
    idle(); step(); idle(); step();
    drv(32'h0000_7F28, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); #1;
    check("ack_no_retrig", cpu_if.cpu_rdata, 32'h0);
    step();

    // Mask, then unmask, then W1C
    drv(32'h0000_7F24, 32'h1, 4'hF, 1'b0, 1'b0, 1'b0); step();
    irq_tc1 = 1'b1;
    idle(); step();
    sync_wait();
    drv(32'h0000_7F28, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); #1;
    check("masked_pend", cpu_if.cpu_rdata, 32'h2);
    check("masked_hwint", {26'h0, hwint}, 32'h0);
    step();
    drv(32'h0000_7F24, 32'h7, 4'hF, 1'b0, 1'b0, 1'b0); step();
    check("unmask_hwint", {26'h0, hwint}, 32'h02);
    drv(32'h0000_7F28, 32'h2, 4'hF, 1'b0, 1'b0, 1'b0); step();
    drv(32'h0000_7F28, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); #1;
    check("w1c_pend", cpu_if.cpu_rdata, 32'h0);
    step();

    // TC0 edge in the same cycle as a CTRL write: set wins
    irq_tc0 = 1'b1;
`ifdef IRQ_SYNC_EN
    idle(); step(); idle(); step();
`endif
    drv(32'h0000_7F00, 32'h1, 4'hF, 1'b0, 1'b0, 1'b0); step();
    drv(32'h0000_7F28, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); #1;
    check("set_wins", cpu_if.cpu_rdata, 32'h1);
    step();
    drv(32'h0000_7F00, 32'h1, 4'hF, 1'b0, 1'b0, 1'b1); #1;
    check("kill_we", {31'h0, tc0_we}, 32'h0);
    step();
    drv(32'h0000_7F28, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); #1;
    check("kill_pend", cpu_if.cpu_rdata, 32'h1);
    step();

    // Build pend=111, reset with sources high, recapture after release
    irq_ext = 1'b0; irq_tc1 = 1'b0;
    idle(); step(); sync_wait();
    irq_ext = 1'b1; irq_tc1 = 1'b1;
    idle(); step(); sync_wait();
    drv(32'h0000_7F28, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); #1;
    check("pend_all", cpu_if.cpu_rdata, 32'h7);
    step();
    reset = 1'b1;
    idle(); step();
    reset = 1'b0;
    check("rst_hwint", {26'h0, hwint}, 32'h0);
    drv(32'h0000_7F24, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); #1;
    check("rst_mask", cpu_if.cpu_rdata, 32'h7);
    step();
    sync_wait();
    drv(32'h0000_7F28, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); #1;
    check("recapture_ext", {31'h0, cpu_if.cpu_rdata[2]}, 32'h1);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0: a = 32'($urandom_range(0, 32'h2FFF));
        1: a = 32'h0000_2FFC + 32'($urandom_range(0, 8));
        2: a = 32'h0000_7F00 + 32'($urandom_range(0, 15));
        3: a = 32'h0000_7F10 + 32'($urandom_range(0, 15));
        4, 5: a = 32'h0000_7F20 + 32'($urandom_range(0, 3) * 4);
        6: a = 32'h0000_7F2C + 32'($urandom_range(0, 8));
        default: a = $urandom;
      endcase
      drv(a, $urandom, be_tab[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
      dm_rdata  = $urandom;
      tc0_rdata = $urandom;
      tc1_rdata = $urandom;
      if ($urandom_range(0, 3) == 0) irq_tc0 = ~irq_tc0;
      if ($urandom_range(0, 3) == 0) irq_tc1 = ~irq_tc1;
      if ($urandom_range(0, 3) == 0) irq_ext = ~irq_ext;
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_bridge_irq_ctrl.md
Name: sys_bridge_irq_ctrl

Overview:
- Bridge and interrupt controller between the CPU M-stage data port and the memory-mapped resources: data memory, two timers (TC0, TC1), and the interrupt-acknowledge window at 0x7F20.
- Decodes addresses, routes writes, muxes read data and flags address-range/size errors.
- Holds sticky, maskable interrupt-pending state that drives CP0 HWInt[5:0].

Parameters:
- DM_TOP, 32'h0000_2FFF, last byte address of data memory (region is 0 .. DM_TOP).
- TC0_BASE, 32'h0000_7F00, TC0 base; 12-byte window (CTRL +0, PRESET +4, COUNT +8).
- TC1_BASE, 32'h0000_7F10, TC1 base; same 12-byte layout.
- INT_BASE, 32'h0000_7F20, interrupt window: ACK +0, MASK +4, PEND +8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_addr  in  32  M-stage byte address
- cpu_wdata  in  32  store data, already byte-lane aligned
- cpu_byteen  in  4  store byte enables; 0 means no store
- cpu_load  in  1  M-stage instruction is a load
- cpu_ld_word  in  1  load is lw (word sized)
- exc_kill  in  1  M-stage instruction is being flushed by an exception; suppresses all side effects
- cpu_rdata  out  32  read data for cpu_addr
- err_load  out  1  load address error (AdEL)
- err_store  out  1  store address error (AdES)
- dm_addr  out  32  forwarded address
- dm_wdata  out  32  forwarded data
- dm_byteen  out  4  DM byte enables
- dm_rdata  in  32  DM read data
- tc0_we / tc1_we  out  1  timer write strobes
- tc_addr  out  30  word address [31:2] to both timers
- tc_wdata  out  32  timer write data
- tc0_rdata / tc1_rdata  in  32  timer read data
- irq_tc0 / irq_tc1 / irq_ext  in  1  level interrupt sources
- int_addr  out  32  ack-window address (to the external interrupter)
- int_byteen  out  4  ack-window byte enables
- hwint  out  6  to CP0: {3'b0, pend & mask}

Behaviour:
- Region decode (combinational):
  - DM: addr <= DM_TOP.
  - TCn: base <= addr < base+12.
  - INT: INT_BASE <= addr < INT_BASE+12.
  - Anything else is unmapped.
- Effective store: st = |cpu_byteen & ~exc_kill. Effective load: ld = cpu_load & ~exc_kill.
- Errors (combinational; when asserted, all write strobes are forced to 0):
  - err_store = st & (unmapped | (TC/INT region & byteen != 4'hF) | TC COUNT offset).
  - err_load = ld & (unmapped | (TC/INT region & ~cpu_ld_word)).
- Write routing:
  - dm_byteen = st & DM ? cpu_byteen : 0.
  - tcN_we = st & TCN region.
  - int_byteen = st & INT region & offset 0 ? cpu_byteen : 0.
  - int_addr = cpu_addr.
- Read mux: DM -> dm_rdata; TCn -> tcn_rdata; INT +4 -> {29'b0, mask}; INT +8 -> {29'b0, pend}; INT +0 and unmapped -> 0.
- Registers (all update on posedge clk):
  - mask[2:0]: reset 3'b111; a full-word write to INT+4 loads wdata[2:0].
  - prev[2:0]: previous sampled level of {ext, tc1, tc0}; reset 0.
  - pend[2:0] (bit0 tc0, bit1 tc1, bit2 ext): reset 0.
    - Set on rising edge (level & ~prev).
    - Cleared by: a TCn CTRL write (bit n); an ACK write (bit2); a W1C full-word write to INT+8 (bits set in wdata[2:0]).
    - Set and clear in the same cycle: set wins, bit stays 1.
- Latency:
  - Source edge sampled at posedge k; pend is high after that edge; hwint reflects it in the same cycle (hwint is combinational from the registers).
  - Ack clears pend at the clock edge ending the store cycle.
- Reset mid-operation: reset clears pend/prev/mask to their reset values. Any source still high at the first non-reset edge is captured as a new edge, because prev is 0.
- Writes when exc_kill=1: no register or strobe effect; errors are not reported.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: every irq input passes a 2-flop synchronizer (reset 0) before edge detection; source-to-pend latency grows by 2 cycles.
- Undefined: inputs go straight to edge detection.

Decomposition:
- Shared package (bridge_pkg): region base constants, offset constants (OFF_CTRL=0, OFF_PRESET=4, OFF_COUNT=8, OFF_ACK=0, OFF_MASK=4, OFF_PEND=8), interrupt bit indices (IRQ_TC0=0, IRQ_TC1=1, IRQ_EXT=2).
- One sub-module, irq_pend_unit: synchronizer option, edge detect, pend/mask registers, hwint.
- Decode, mux and errors stay in the top.

Test Plan:
- sw 0x12345678 to 0x0000_0010, byteen F -> dm_byteen=F, tc/int strobes 0, no error; lw same address -> cpu_rdata=dm_rdata.
- sb to 0x7F04 (byteen 4'h1) -> err_store=1, tc0_we=0. sw to 0x7F08 -> err_store=1. lh from 0x7F14 -> err_load=1. lw from 0x5000 -> err_load=1, rdata 0.
- irq_ext rises at cycle 10 -> pend=3'b100, hwint=6'b000100. sw to 0x7F20 -> int_byteen=F, pend[2]=0 next cycle; irq_ext still high -> no re-trigger.
- mask written 3'b001 with irq_tc1 rising -> pend[1]=1, hwint=0. Write 3'b111 -> hwint=6'b000010. W1C write 0x2 to 0x7F28 -> pend=0.
- irq_tc0 edge in the same cycle as a TC0 CTRL write -> pend[0] stays 1. The same store with exc_kill=1 -> tc0_we=0, pend unchanged.
- Reset asserted while pend=3'b111 and irq_ext high -> pend=0, mask=7. After release: pend[2]=1 at the next edge (+2 cycles with IRQ_SYNC_EN).
